// File: rtl/parking_gate_ctrl.sv
// Parking lot entry gate controller with hour-dependent university reservation.
// Tracks cars in a university zone and a general zone, decides entry requests,
// holds the barrier open for a bounded time and processes exits.
module parking_gate_ctrl #(
    parameter int TOTAL_SPACE     = 700,
    parameter int INIT_UNI_SPACE  = 500,
    parameter int FINAL_UNI_SPACE = 200,
    parameter int STEP            = 50,
    parameter int OPEN_HOUR       = 8,
    parameter int RAMP_HOUR       = 13,
    parameter int CNT_W           = 10,
    parameter int GATE_TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       hour,
    input  logic             entry_req,
    input  logic             entry_is_uni,
    input  logic             entry_passed,
    input  logic             exit_pulse,
    input  logic             exit_is_uni,
    output logic             entry_ack,
    output logic             entry_granted,
    output logic             gate_open,
    output logic [CNT_W-1:0] uni_parked,
    output logic [CNT_W-1:0] gen_parked,
    output logic [CNT_W-1:0] uni_free,
    output logic [CNT_W-1:0] gen_free,
    output logic             lot_closed,
    output logic [15:0]      deny_cnt,
    output logic             exit_err
);

    localparam int TMR_W = $clog2(GATE_TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_OPEN} state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             zone_uni_q, zone_uni_d;
    logic             gate_open_q, gate_open_d;
    logic             ack_q, ack_d;
    logic             granted_q, granted_d;
    logic             exit_err_q, exit_err_d;
    logic [15:0]      deny_cnt_q, deny_cnt_d;
    logic [CNT_W-1:0] uni_parked_q, uni_parked_d;
    logic [CNT_W-1:0] gen_parked_q, gen_parked_d;
    logic [CNT_W-1:0] uni_free_q, uni_free_d;
    logic [CNT_W-1:0] gen_free_q, gen_free_d;
    logic [CNT_W-1:0] uni_cap_q, uni_cap_d;
    logic             lot_closed_q, lot_closed_d;

    logic             commit;       // car cleared the gate this cycle
    logic [CNT_W:0]   total_q;
    logic             room_q;

    assign total_q = {1'b0, uni_parked_q} + {1'b0, gen_parked_q};
    assign room_q  = total_q < (CNT_W+1)'(TOTAL_SPACE);

    // Reservation size and open-window flag from the current hour
    always_comb begin
        int hr;
        int dec;
        hr           = int'(hour);
        dec          = 0;
        uni_cap_d    = CNT_W'(FINAL_UNI_SPACE);
        lot_closed_d = (hr < OPEN_HOUR) || (hr > 23);
        if (hr >= OPEN_HOUR && hr < RAMP_HOUR) begin
            uni_cap_d = CNT_W'(INIT_UNI_SPACE);
        end else if (hr >= RAMP_HOUR && hr <= 23) begin
            dec = STEP * (hr - RAMP_HOUR + 1);
            if (INIT_UNI_SPACE - dec > FINAL_UNI_SPACE)
                uni_cap_d = CNT_W'(INIT_UNI_SPACE - dec);
        end
    end

    // Entry FSM: decide in IDLE, hold the barrier in OPEN until pass or timeout.
    // The cycle showing entry_ack is skipped so a still-held request is not
    // decided twice after a deny.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        zone_uni_d  = zone_uni_q;
        gate_open_d = gate_open_q;
        ack_d       = 1'b0;
        granted_d   = 1'b0;
        deny_cnt_d  = deny_cnt_q;
        commit      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (entry_req && !ack_q) begin
                    ack_d = 1'b1;
                    if (!lot_closed_q && room_q && entry_is_uni && uni_free_q != '0) begin
                        granted_d  = 1'b1;
                        zone_uni_d = 1'b1;
                    end else if (!lot_closed_q && room_q && gen_free_q != '0) begin
                        granted_d  = 1'b1;
                        zone_uni_d = 1'b0;
                    end
                    if (granted_d) begin
                        state_d     = S_OPEN;
                        timer_d     = TMR_W'(GATE_TIMEOUT);
                        gate_open_d = 1'b1;
                    end else if (deny_cnt_q != 16'hFFFF) begin
                        deny_cnt_d = deny_cnt_q + 16'd1;
                    end
                end
            end
            S_OPEN: begin
                if (entry_passed) begin
                    commit      = 1'b1;
                    state_d     = S_IDLE;
                    gate_open_d = 1'b0;
                end else if (timer_q <= TMR_W'(1)) begin
                    state_d     = S_IDLE;
                    gate_open_d = 1'b0;
                    timer_d     = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d     = S_IDLE;
                gate_open_d = 1'b0;
            end
        endcase
    end

    // Occupancy update: reclassify excess uni cars, then exit, then entry
    always_comb begin
        logic [CNT_W-1:0] uni_r, gen_r;
        logic [CNT_W-1:0] gen_cap;
        uni_r      = uni_parked_q;
        gen_r      = gen_parked_q;
        exit_err_d = 1'b0;
        if (uni_parked_q > uni_cap_q) begin
            uni_r = uni_cap_q;
            gen_r = gen_parked_q + (uni_parked_q - uni_cap_q);
        end
        if (exit_pulse) begin
            if (exit_is_uni && uni_r != '0)
                uni_r = uni_r - CNT_W'(1);
            else if (gen_r != '0)
                gen_r = gen_r - CNT_W'(1);
            else
                exit_err_d = 1'b1;
        end
        // Grants already require a free slot; the total guard only keeps
        // the counts from ever exceeding lot capacity.
        if (commit && ({1'b0, uni_r} + {1'b0, gen_r}) < (CNT_W+1)'(TOTAL_SPACE)) begin
            if (zone_uni_q) uni_r = uni_r + CNT_W'(1);
            else            gen_r = gen_r + CNT_W'(1);
        end
        uni_parked_d = uni_r;
        gen_parked_d = gen_r;
        // Free counts follow the values being registered this edge
        gen_cap    = CNT_W'(TOTAL_SPACE) - uni_cap_d;
        uni_free_d = (uni_cap_d > uni_r) ? uni_cap_d - uni_r : '0;
        gen_free_d = (gen_cap > gen_r) ? gen_cap - gen_r : '0;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            zone_uni_q   <= 1'b0;
            gate_open_q  <= 1'b0;
            ack_q        <= 1'b0;
            granted_q    <= 1'b0;
            exit_err_q   <= 1'b0;
            deny_cnt_q   <= '0;
            uni_parked_q <= '0;
            gen_parked_q <= '0;
            uni_cap_q    <= CNT_W'(INIT_UNI_SPACE);
            uni_free_q   <= CNT_W'(INIT_UNI_SPACE);
            gen_free_q   <= CNT_W'(TOTAL_SPACE - INIT_UNI_SPACE);
            lot_closed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            zone_uni_q   <= zone_uni_d;
            gate_open_q  <= gate_open_d;
            ack_q        <= ack_d;
            granted_q    <= granted_d;
            exit_err_q   <= exit_err_d;
            deny_cnt_q   <= deny_cnt_d;
            uni_parked_q <= uni_parked_d;
            gen_parked_q <= gen_parked_d;
            uni_cap_q    <= uni_cap_d;
            uni_free_q   <= uni_free_d;
            gen_free_q   <= gen_free_d;
            lot_closed_q <= lot_closed_d;
        end
    end

    assign entry_ack     = ack_q;
    assign entry_granted = granted_q;
    assign gate_open     = gate_open_q;
    assign uni_parked    = uni_parked_q;
    assign gen_parked    = gen_parked_q;
    assign uni_free      = uni_free_q;
    assign gen_free      = gen_free_q;
    assign lot_closed    = lot_closed_q;
    assign deny_cnt      = deny_cnt_q;
    assign exit_err      = exit_err_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with hand-computed expectations.
module tb_parking_gate_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  hour;
    logic        entry_req, entry_is_uni, entry_passed, exit_pulse, exit_is_uni;
    logic        entry_ack, entry_granted, gate_open, lot_closed, exit_err;
    logic [9:0]  uni_parked, gen_parked, uni_free, gen_free;
    logic [15:0] deny_cnt;

    int checks   = 0;
    int failures = 0;
    logic gr;

    parking_gate_ctrl dut (
        .clk(clk), .rst_n(rst_n), .hour(hour),
        .entry_req(entry_req), .entry_is_uni(entry_is_uni),
        .entry_passed(entry_passed), .exit_pulse(exit_pulse), .exit_is_uni(exit_is_uni),
        .entry_ack(entry_ack), .entry_granted(entry_granted), .gate_open(gate_open),
        .uni_parked(uni_parked), .gen_parked(gen_parked),
        .uni_free(uni_free), .gen_free(gen_free),
        .lot_closed(lot_closed), .deny_cnt(deny_cnt), .exit_err(exit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Raise a request and wait (bounded) for the decision pulse
    task automatic req(input logic uni, output logic granted);
        int n;
        n = 0;
        entry_req = 1'b1; entry_is_uni = uni;
        do begin step(1); n++; end while (!entry_ack && n < 10);
        if (!entry_ack) chk("ack_timeout", 32'(entry_ack), 32'd1);
        granted = entry_granted;
        entry_req = 1'b0;
    endtask

    task automatic pass_car();
        entry_passed = 1'b1; step(1); entry_passed = 1'b0;
    endtask

    task automatic leave(input logic uni);
        exit_pulse = 1'b1; exit_is_uni = uni; step(1); exit_pulse = 1'b0;
    endtask

    task automatic fill(input logic uni, input int n);
        logic g;
        repeat (n) begin req(uni, g); pass_car(); end
    endtask

    initial begin
        rst_n = 1'b0; hour = 6'd9;
        entry_req = 0; entry_is_uni = 0; entry_passed = 0; exit_pulse = 0; exit_is_uni = 0;
        #12;
        chk("rst_uni_free", 32'(uni_free), 32'd500);
        chk("rst_gen_free", 32'(gen_free), 32'd200);
        chk("rst_counts",   32'(uni_parked + gen_parked), 32'd0);
        chk("rst_gate",     32'(gate_open), 32'd0);
        chk("rst_closed",   32'(lot_closed), 32'd0);
        chk("rst_deny",     32'(deny_cnt), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        step(2);

        // uni car granted, passes three cycles after grant
        req(1'b1, gr);
        chk("uni_grant", 32'(gr), 32'd1);
        chk("gate_up", 32'(gate_open), 32'd1);
        step(2); pass_car();
        chk("uni_parked_1", 32'(uni_parked), 32'd1);
        chk("uni_free_499", 32'(uni_free), 32'd499);
        chk("gate_down", 32'(gate_open), 32'd0);

        // gate times out after 16 cycles with no pass
        req(1'b0, gr);
        chk("to_grant", 32'(gr), 32'd1);
        step(15);
        chk("to_still_open", 32'(gate_open), 32'd1);
        step(1);
        chk("to_closed", 32'(gate_open), 32'd0);
        chk("to_counts", 32'({uni_parked, gen_parked}), 32'({10'd1, 10'd0}));
        req(1'b0, gr);
        chk("after_to_grant", 32'(gr), 32'd1);
        pass_car();
        chk("gen_parked_1", 32'(gen_parked), 32'd1);

        // closed lot: deny, exits still work, exit_err when zone empty
        hour = 6'd7; step(2);
        chk("closed", 32'(lot_closed), 32'd1);
        chk("closed_uni_free", 32'(uni_free), 32'd199);
        req(1'b1, gr);
        chk("closed_deny", 32'(gr), 32'd0);
        chk("deny_cnt_1", 32'(deny_cnt), 32'd1);
        step(1);
        chk("deny_no_gate", 32'(gate_open), 32'd0);
        chk("deny_single", 32'(deny_cnt), 32'd1);
        leave(1'b0);
        chk("closed_exit", 32'(gen_parked), 32'd0);
        chk("exit_ok", 32'(exit_err), 32'd0);
        leave(1'b0);
        chk("exit_err", 32'(exit_err), 32'd1);
        chk("exit_err_uni", 32'(uni_parked), 32'd1);
        step(1);
        chk("exit_err_pulse", 32'(exit_err), 32'd0);

        // fill uni zone; uni request then lands in general zone
        hour = 6'd9; step(2);
        fill(1'b1, 499);
        chk("uni_full", 32'(uni_parked), 32'd500);
        chk("uni_free_0", 32'(uni_free), 32'd0);
        req(1'b1, gr);
        chk("uni_to_gen_grant", 32'(gr), 32'd1);
        pass_car();
        chk("gen_after_uni", 32'(gen_parked), 32'd1);
        chk("gen_free_199", 32'(gen_free), 32'd199);
        chk("uni_unchanged", 32'(uni_parked), 32'd500);

        // entry and exit in the same cycle at one below capacity
        fill(1'b0, 198);
        chk("gen_199", 32'(gen_parked), 32'd199);
        req(1'b0, gr);
        chk("last_slot_grant", 32'(gr), 32'd1);
        entry_passed = 1'b1; exit_pulse = 1'b1; exit_is_uni = 1'b0;
        step(1);
        entry_passed = 1'b0; exit_pulse = 1'b0;
        chk("same_cyc_gen", 32'(gen_parked), 32'd199);
        chk("same_cyc_uni", 32'(uni_parked), 32'd500);
        chk("same_cyc_err", 32'(exit_err), 32'd0);
        fill(1'b0, 1);
        chk("full_gen_free", 32'(gen_free), 32'd0);
        chk("full_total", 32'(uni_parked + gen_parked), 32'd700);
        req(1'b1, gr);
        chk("full_deny", 32'(gr), 32'd0);
        chk("deny_cnt_2", 32'(deny_cnt), 32'd2);

        // reservation shrink moves excess uni cars to general
        repeat (20) leave(1'b1);
        chk("uni_480", 32'(uni_parked), 32'd480);
        hour = 6'd12; step(2);
        chk("h12_uni_free", 32'(uni_free), 32'd20);
        hour = 6'd14; step(1);
        chk("h14_uni_before", 32'(uni_parked), 32'd480);
        chk("h14_uni_free", 32'(uni_free), 32'd0);
        chk("h14_gen_free", 32'(gen_free), 32'd100);
        step(1);
        chk("recl_uni", 32'(uni_parked), 32'd400);
        chk("recl_gen", 32'(gen_parked), 32'd280);
        chk("recl_gen_free", 32'(gen_free), 32'd20);

        // late hours clamp at the reservation floor
        hour = 6'd23; step(1);
        chk("h23_gen_free_a", 32'(gen_free), 32'd220);
        step(1);
        chk("floor_uni", 32'(uni_parked), 32'd200);
        chk("floor_gen", 32'(gen_parked), 32'd480);
        chk("floor_gen_free", 32'(gen_free), 32'd20);
        chk("h23_open", 32'(lot_closed), 32'd0);
        hour = 6'd24; step(1);
        chk("h24_closed", 32'(lot_closed), 32'd1);
        hour = 6'd23; step(1);

        // reset while gate is open drops the pending car
        req(1'b0, gr);
        chk("pre_rst_grant", 32'(gr), 32'd1);
        chk("pre_rst_gate", 32'(gate_open), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_open_gate", 32'(gate_open), 32'd0);
        chk("rst_open_gen", 32'(gen_parked), 32'd0);
        chk("rst_open_uni_free", 32'(uni_free), 32'd500);
        chk("rst_open_deny", 32'(deny_cnt), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        pass_car();
        chk("post_rst_pass_ignored", 32'(gen_parked), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
